// File: rtl/demux_striping_n.sv
// N-lane round-robin word striping demultiplexer with slot/packed pointer modes and alignment.
// Optional per-lane word counters are enabled by defining STRIPE_STATS_EN.
module demux_striping_n #(
    parameter int unsigned LANES  = 4,
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned PACKED = 0,
    parameter int unsigned SEL_W  = $clog2(LANES)
) (
    input  logic                     clk_2f,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         data_in,
    input  logic                     valid_in,
    input  logic                     align_in,
`ifdef STRIPE_STATS_EN
    input  logic                     cnt_clr,
    output logic [LANES*16-1:0]      lane_cnt_out,
`endif
    output logic [LANES*WIDTH-1:0]   lane_data_out,
    output logic [LANES-1:0]         lane_valid_out,
    output logic                     stripe_done,
    output logic [SEL_W-1:0]         lane_sel
);

    logic [WIDTH-1:0] data_q [LANES];
    logic [WIDTH-1:0] data_d [LANES];
    logic [LANES-1:0] valid_q, valid_d;
    logic             done_q, done_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [SEL_W-1:0] tgt;

    always_comb begin
        tgt     = align_in ? '0 : sel_q;
        data_d  = data_q;
        valid_d = '0;
        done_d  = 1'b0;
        if (valid_in) begin
            for (int i = 0; i < LANES; i++) begin
                if (tgt == SEL_W'(i)) begin
                    data_d[i]  = data_in;
                    valid_d[i] = 1'b1;
                end
            end
            done_d = (tgt == SEL_W'(LANES - 1));
        end
        // Packed mode only consumes a slot when a word is written; wrap is free (power of two).
        if ((PACKED != 0) && !valid_in) begin
            sel_d = tgt;
        end else begin
            sel_d = tgt + SEL_W'(1);
        end
    end

    always_ff @(posedge clk_2f or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < LANES; i++) begin
                data_q[i] <= '0;
            end
            valid_q <= '0;
            done_q  <= 1'b0;
            sel_q   <= '0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            sel_q   <= sel_d;
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane_out
        assign lane_data_out[g*WIDTH +: WIDTH] = data_q[g];
    end

    assign lane_valid_out = valid_q;
    assign stripe_done    = done_q;
    assign lane_sel       = sel_q;

`ifdef STRIPE_STATS_EN
    logic [15:0] cnt_q [LANES];
    logic [15:0] cnt_d [LANES];

    // Clear wins over a same-cycle increment.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            cnt_d[i] = cnt_clr ? 16'd0 : cnt_q[i] + {15'd0, valid_d[i]};
        end
    end

    always_ff @(posedge clk_2f or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < LANES; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            cnt_q <= cnt_d;
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_cnt_out
        assign lane_cnt_out[g*16 +: 16] = cnt_q[g];
    end
`endif

endmodule
